// File: rtl/packet_slot_allocator_pkg.sv
// Shared packet-controller types: slot index, free-count width and buffer slot count.
package packet_slot_allocator_pkg;
  localparam int SLOT_COUNT = 8;
  localparam int SLOT_IDX_W = $clog2(SLOT_COUNT);
  localparam int FREE_CNT_W = $clog2(SLOT_COUNT + 1);

  typedef logic [SLOT_IDX_W-1:0] slot_idx_t;
  typedef logic [FREE_CNT_W-1:0] free_cnt_t;
endpackage

// File: rtl/packet_slot_allocator_if.sv
// Allocation/free bus between requesters and the slot allocator.
// double_free_err exists only when PACKET_SLOT_DOUBLE_FREE_CHECK_EN is defined.
interface packet_slot_allocator_if
  import packet_slot_allocator_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] alloc_req;
  logic [NUM_REQ-1:0] alloc_gnt;
  slot_idx_t          alloc_index;
  logic               free_valid;
  slot_idx_t          free_index;
  free_cnt_t          free_count;
  logic               all_busy;
  logic               all_free;
`ifdef PACKET_SLOT_DOUBLE_FREE_CHECK_EN
  logic               double_free_err;

  modport master (
    output alloc_req, free_valid, free_index,
    input  alloc_gnt, alloc_index, free_count, all_busy, all_free, double_free_err
  );
  modport slave (
    input  alloc_req, free_valid, free_index,
    output alloc_gnt, alloc_index, free_count, all_busy, all_free, double_free_err
  );
`else
  modport master (
    output alloc_req, free_valid, free_index,
    input  alloc_gnt, alloc_index, free_count, all_busy, all_free
  );
  modport slave (
    input  alloc_req, free_valid, free_index,
    output alloc_gnt, alloc_index, free_count, all_busy, all_free
  );
`endif
endinterface

// File: rtl/packet_slot_allocator_free_slot_finder.sv
// Combinational highest-set-bit priority encoder over the free-slot bitmap.
module free_slot_finder
  import packet_slot_allocator_pkg::*;
#(
  parameter int NUM_ENTRIES = SLOT_COUNT
) (
  input  logic [NUM_ENTRIES-1:0] i_bitmap,
  output logic                   o_valid,
  output slot_idx_t              o_index
);

  always_comb begin
    o_valid = |i_bitmap;
    o_index = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (i_bitmap[i]) o_index = slot_idx_t'(i);
    end
  end

endmodule

// File: rtl/packet_slot_allocator.sv
// Packet-buffer slot allocator: free bitmap, round-robin grant, incremental free count.
// Optional sticky double-free detection under PACKET_SLOT_DOUBLE_FREE_CHECK_EN.
module packet_slot_allocator
  import packet_slot_allocator_pkg::*;
#(
  parameter int NUM_ENTRIES = SLOT_COUNT,
  parameter int NUM_REQ     = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  packet_slot_allocator_if.slave  io_bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_ENTRIES-1:0] r_bitmap;
  logic [NUM_ENTRIES-1:0] w_bitmap_next;
  logic [NUM_REQ-1:0]     r_gnt;
  logic [NUM_REQ-1:0]     w_gnt_next;
  logic [NUM_REQ-1:0]     w_elig;
  logic [2*NUM_REQ-1:0]   w_elig_rot;
  slot_idx_t              r_index;
  free_cnt_t              r_count;
  free_cnt_t              w_count_next;
  logic                   r_all_busy;
  logic                   r_all_free;
  logic [PTR_W-1:0]       r_ptr;
  logic [PTR_W-1:0]       w_ptr_next;
  logic [PTR_W-1:0]       w_off;
  logic [PTR_W-1:0]       w_winner;
  logic [PTR_W:0]         w_sum;
  logic [PTR_W:0]         w_sum_wrap;
  logic                   w_win;
  logic                   w_grant;
  logic                   w_sel_valid;
  slot_idx_t              w_sel_idx;
  logic                   w_real_free;

  free_slot_finder #(.NUM_ENTRIES(NUM_ENTRIES)) u_finder (
    .i_bitmap (r_bitmap),
    .o_valid  (w_sel_valid),
    .o_index  (w_sel_idx)
  );

  // A requester sitting in its grant cycle is excluded so it cannot win twice.
  assign w_elig     = io_bus.alloc_req & ~r_gnt;
  assign w_elig_rot = {w_elig, w_elig} >> r_ptr;

  always_comb begin
    w_win = 1'b0;
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_elig_rot[k]) begin
        w_win = 1'b1;
        w_off = PTR_W'(k);
      end
    end
  end

  assign w_sum      = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_sum_wrap = w_sum - (PTR_W + 1)'(NUM_REQ);
  assign w_winner   = (w_sum >= (PTR_W + 1)'(NUM_REQ)) ? w_sum_wrap[PTR_W-1:0] : w_sum[PTR_W-1:0];
  assign w_ptr_next = (w_winner == PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + PTR_W'(1);
  assign w_grant    = w_win & w_sel_valid;

  always_comb begin
    w_gnt_next = '0;
    if (w_grant) w_gnt_next[w_winner] = 1'b1;
  end

  // Only a free of a currently-held slot changes the count; allocation reads the pre-edge bitmap.
  assign w_real_free = io_bus.free_valid & ~r_bitmap[io_bus.free_index];

  always_comb begin
    w_bitmap_next = r_bitmap;
    if (io_bus.free_valid) w_bitmap_next[io_bus.free_index] = 1'b1;
    if (w_grant)           w_bitmap_next[w_sel_idx]         = 1'b0;
  end

  assign w_count_next = r_count - free_cnt_t'(w_grant) + free_cnt_t'(w_real_free);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bitmap   <= '1;
      r_gnt      <= '0;
      r_index    <= '0;
      r_count    <= free_cnt_t'(NUM_ENTRIES);
      r_all_busy <= 1'b0;
      r_all_free <= 1'b1;
      r_ptr      <= '0;
    end else begin
      r_bitmap   <= w_bitmap_next;
      r_gnt      <= w_gnt_next;
      r_count    <= w_count_next;
      r_all_busy <= (w_count_next == '0);
      r_all_free <= (w_count_next == free_cnt_t'(NUM_ENTRIES));
      if (w_grant) begin
        r_index <= w_sel_idx;
        r_ptr   <= w_ptr_next;
      end
    end
  end

  assign io_bus.alloc_gnt   = r_gnt;
  assign io_bus.alloc_index = r_index;
  assign io_bus.free_count  = r_count;
  assign io_bus.all_busy    = r_all_busy;
  assign io_bus.all_free    = r_all_free;

`ifdef PACKET_SLOT_DOUBLE_FREE_CHECK_EN
  logic r_double_free_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_double_free_err <= 1'b0;
    end else if (io_bus.free_valid &&
                 (r_bitmap[io_bus.free_index] || (w_grant && (io_bus.free_index == w_sel_idx)))) begin
      r_double_free_err <= 1'b1;
    end
  end

  assign io_bus.double_free_err = r_double_free_err;
`endif

endmodule

// File: tb/tb_packet_slot_allocator.sv
// Directed self-checking bench for packet_slot_allocator (8 slots, 4 requesters).
// Double-free checks run only when PACKET_SLOT_DOUBLE_FREE_CHECK_EN is defined.
module tb_packet_slot_allocator;
  import packet_slot_allocator_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  packet_slot_allocator_if #(.NUM_REQ(4)) bus ();

  packet_slot_allocator #(.NUM_ENTRIES(8), .NUM_REQ(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic fv, input logic [2:0] fi);
    bus.alloc_req  = req;
    bus.free_valid = fv;
    bus.free_index = fi;
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] expGnt, input logic [2:0] expIdx,
                             input logic [3:0] expCnt, input logic expBusy, input logic expFree);
    checks++;
    assert (bus.alloc_gnt === expGnt) else begin
      errors++;
      $error("[TB] FAIL %s gnt: observed %b expected %b", tag, bus.alloc_gnt, expGnt);
    end
    if (expGnt != 4'b0000) begin
      checks++;
      assert (bus.alloc_index === expIdx) else begin
        errors++;
        $error("[TB] FAIL %s index: observed %0d expected %0d", tag, bus.alloc_index, expIdx);
      end
    end
    checks++;
    assert (bus.free_count === expCnt) else begin
      errors++;
      $error("[TB] FAIL %s count: observed %0d expected %0d", tag, bus.free_count, expCnt);
    end
    checkBit({tag, " busy"}, bus.all_busy, expBusy);
    checkBit({tag, " allfree"}, bus.all_free, expFree);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput(tag, 4'b0000, 3'd0, 4'd8, 1'b0, 1'b1);
    checks++;
    assert (bus.alloc_index === 3'd0) else begin
      errors++;
      $error("[TB] FAIL %s index: observed %0d expected 0", tag, bus.alloc_index);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    applyStimulus(4'b0000, 1'b0, 3'd0);
    #12;
    checkResetState("reset");
`ifdef PACKET_SLOT_DOUBLE_FREE_CHECK_EN
    checkBit("reset dferr", bus.double_free_err, 1'b0);
`endif
    doReset();

    // Single requester holding req: grants every other cycle, indices 7,6,5,4.
    applyStimulus(4'b0001, 1'b0, 3'd0);
    for (int k = 1; k <= 8; k++) begin
      stepCycle();
      if (k % 2 == 1)
        checkOutput($sformatf("single k%0d", k), 4'b0001, 3'(8 - (k + 1) / 2),
                    4'(8 - (k + 1) / 2), 1'b0, 1'b0);
      else
        checkOutput($sformatf("single k%0d", k), 4'b0000, 3'd0, 4'(8 - k / 2), 1'b0, 1'b0);
    end

    applyStimulus(4'b0000, 1'b0, 3'd0);
    doReset();
    checkResetState("reset2");

    // All four requesters: rotate 0,1,2,3 with indices 7 down to 0, then pool exhausted.
    applyStimulus(4'b1111, 1'b0, 3'd0);
    for (int k = 1; k <= 8; k++) begin
      stepCycle();
      checkOutput($sformatf("rr k%0d", k), 4'(1 << ((k - 1) % 4)), 3'(8 - k), 4'(8 - k),
                  k == 8, 1'b0);
    end
    stepCycle();
    checkOutput("busy k9", 4'b0000, 3'd0, 4'd0, 1'b1, 1'b0);
    stepCycle();
    checkOutput("busy k10", 4'b0000, 3'd0, 4'd0, 1'b1, 1'b0);

    // Full pool, requester 2 pending, slot 3 released.
    applyStimulus(4'b0100, 1'b1, 3'd3);
    stepCycle();
    checkOutput("free3", 4'b0000, 3'd0, 4'd1, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 3'd0);
    stepCycle();
    checkOutput("regrant3", 4'b0100, 3'd3, 4'd0, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0, 3'd0);
    stepCycle();
    checkOutput("idle", 4'b0000, 3'd0, 4'd0, 1'b1, 1'b0);

    // Free 5, then allocate 5 while freeing 0 in the same cycle, then grant 0.
    applyStimulus(4'b0000, 1'b1, 3'd5);
    stepCycle();
    checkOutput("free5", 4'b0000, 3'd0, 4'd1, 1'b0, 1'b0);
    applyStimulus(4'b0010, 1'b1, 3'd0);
    stepCycle();
    checkOutput("alloc5 free0", 4'b0010, 3'd5, 4'd1, 1'b0, 1'b0);
    applyStimulus(4'b1000, 1'b0, 3'd0);
    stepCycle();
    checkOutput("alloc0", 4'b1000, 3'd0, 4'd0, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0, 3'd0);
    stepCycle();
    checkOutput("idle2", 4'b0000, 3'd0, 4'd0, 1'b1, 1'b0);

    // Freeing an already-free slot leaves the count alone.
    doReset();
    applyStimulus(4'b0000, 1'b1, 3'd2);
    stepCycle();
    applyStimulus(4'b0000, 1'b0, 3'd0);
    checkOutput("dblfree", 4'b0000, 3'd0, 4'd8, 1'b0, 1'b1);
`ifdef PACKET_SLOT_DOUBLE_FREE_CHECK_EN
    checkBit("dferr set", bus.double_free_err, 1'b1);
    repeat (3) stepCycle();
    checkBit("dferr sticky", bus.double_free_err, 1'b1);
`endif

    // Async reset mid-stream with five slots allocated and a grant pending.
    doReset();
`ifdef PACKET_SLOT_DOUBLE_FREE_CHECK_EN
    checkBit("dferr cleared", bus.double_free_err, 1'b0);
`endif
    applyStimulus(4'b1111, 1'b0, 3'd0);
    repeat (5) stepCycle();
    checkOutput("pre-reset", 4'b0001, 3'd3, 4'd3, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkResetState("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("post-reset", 4'b0001, 3'd7, 4'd7, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
